cfi_commit_monitor: RTL and testbench
=====================================

# cfi_commit_monitor

Control-flow integrity monitor on the commit stage, generalised to any number of commit ports. It watches acknowledged commits, requires every call to be followed by a call-entry marker and every return by a return-landing marker, and checks that each return lands where a shadow stack says it should. It raises a registered BREAKPOINT exception toward the commit/CSR path on any violation. It also drives sticky status bits for board LEDs.

## Interface
- NR_COMMIT_PORTS, 2: commit ports scanned per cycle, 1..4.
- SS_DEPTH, 8: shadow-stack entries, power of two, 2..64.
- MARKER_OP, ariane_pkg::ADD: marker opcode.
- MARKER_RD, 5'd0: marker destination register.
- MARKER_RS1, 5'd0: marker source register.
- MARKER_IMM_CALL, 5'h2: marker imm (result[4:0]) at a callee entry.
- MARKER_IMM_RET, 5'h1: marker imm at a return landing.
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- flush_i  in  1  pipeline flush. Clears pending-marker state only.
- en_i  in  1  CSR enable for exception reporting.
- commit_ack_i  in  NR_COMMIT_PORTS  per-port commit acknowledge.
- commit_instr_i  in  scoreboard_entry_t[NR_COMMIT_PORTS]  committing instructions.
- exception_o  out  exception_t  violation report: valid, cause, tval.
- status_o  out  5  sticky flags: [0] en_i registered, [1] marker violation, [2] shadow mismatch, [3] overflow, [4] underflow.

## Operation
- Committed stream per cycle: ports 0..N-1 in order, stopping at the first port with ack=0. An ack on a higher port after a gap is ignored.
- Each stream entry is processed sequentially within the cycle. The next entry sees the state updated by the previous one.
- Entry with ex.valid=1: clears pending state (trap entry). It is not classified and not checked.
- Classification:
  - call: op JAL/JALR with rd≠0.
  - ret: op JALR with rd=0 and rs1=1.
  - marker-call / marker-ret: op, rd, rs1 and result[4:0] all equal the MARKER parameters with the matching imm.
- Pending state FSM, one register: IDLE, WAIT_CALL_MK, WAIT_RET_MK.
  - IDLE: call → WAIT_CALL_MK; ret → WAIT_RET_MK; anything else stays IDLE.
  - WAIT_CALL_MK: the next entry must be marker-call, otherwise marker violation. Then evaluate that entry from IDLE, so a call on the checked entry rearms the FSM.
  - WAIT_RET_MK: the next entry must be marker-ret, otherwise marker violation. Shadow check runs on this entry. Then evaluate the entry from IDLE.
- Shadow stack: circular buffer of SS_DEPTH return addresses, write pointer plus count.
  - Push on call: pc + (is_compressed ? 2 : 4).
  - Pop on ret.
  - Shadow check: the ret-marker pc must equal the popped address, otherwise shadow mismatch.
- Overflow: push when count=SS_DEPTH overwrites the oldest entry. Count stays SS_DEPTH; status_o[3] is set.
- Underflow: pop when count=0 skips the shadow check, sets status_o[4], and raises no violation.
- Multiple violations in a cycle: only the first in stream order is reported; the rest are dropped.
- Reporting:
  - Violation with en_i=1: exception_o.valid=1, cause=riscv::BREAKPOINT, tval=pc of the offending entry (the non-marker entry, or the mismatching ret-marker).
  - With en_i=0: tracking, stack updates and status flags continue, but no exception is raised.
  - A reported violation returns the FSM to IDLE.
- flush_i=1: FSM goes to IDLE at the next edge. Stack and status are untouched. Commits in the flush cycle are still processed, but the final FSM state is IDLE.

## Timing
- Reset, during the rst_i cycle edge: FSM IDLE, stack count 0, pointer 0, exception_o all zero, status_o 5'b0.
- exception_o is registered: valid for exactly one cycle, on the cycle after the offending commit. Cause and tval are zero whenever valid=0.
- Violation in back-to-back cycles gives valid high on consecutive cycles, each with its own tval.
- Reset asserted mid-sequence discards pending state and stack contents at that edge.
- status_o[0] follows en_i with one cycle of delay. Bits [4:1] set one cycle after their event and clear only on reset.

## Configuration
- CFI_SHADOW_STACK_EN defined: shadow stack, shadow check, and overflow/underflow flags as above.
- Not defined:
  - No stack storage; SS_DEPTH is unused.
  - Only marker checks apply.
  - status_o[4:2] are tied to 0.

## Test plan
- Port0 JAL rd=1 at pc 0x100, port1 marker-call, same cycle → no exception. Next cycle, ret then marker-ret at pc 0x104 → no exception; stack count back to 0.
- JALR ret acked alone on port0, then next cycle port0 ADD x0,x0,3 at pc 0x200, en_i=1 → one cycle later exception_o.valid=1, cause BREAKPOINT, tval 0x200.
- Call at pc 0x300, compressed, plus marker. Later ret plus marker-ret at pc 0x304 → shadow mismatch, tval 0x304, status_o[2]=1 (expected landing 0x302).
- SS_DEPTH+1 nested calls with markers, then SS_DEPTH+1 rets with correct landings → status_o[3]=1. Final ret skips the check, status_o[4]=1, no exception.
- Ret committed, flush_i in the same cycle, next commit a non-marker → no exception, FSM IDLE.
- Same violation with en_i=0 → exception_o.valid stays 0; status_o[1] goes to 1.

Source files
------------

// File: rtl/cfi_commit_monitor_if.sv
// Commit-stage types and the commit/exception bundle observed by cfi_commit_monitor.
// The package holds the minimal subset of core types the monitor needs.
package cfi_commit_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, XORL, SLL, SRL, JAL, JALR, BEQ, BNE, LD, SD
  } fu_op;

  localparam logic [63:0] BREAKPOINT = 64'd3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_op        op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [63:0] result;
    logic        is_compressed;
    exception_t  ex;
  } scoreboard_entry_t;

endpackage

interface cfi_commit_monitor_if #(
  parameter int unsigned NR_COMMIT_PORTS = 2
);
  import cfi_commit_pkg::*;

  logic                                 flush_i;
  logic                                 en_i;
  logic              [NR_COMMIT_PORTS-1:0] commit_ack_i;
  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i;
  exception_t                           exception_o;
  logic              [4:0]              status_o;

  modport master (
    output flush_i, en_i, commit_ack_i, commit_instr_i,
    input  exception_o, status_o
  );

  modport slave (
    input  flush_i, en_i, commit_ack_i, commit_instr_i,
    output exception_o, status_o
  );

endinterface

// File: rtl/cfi_commit_monitor.sv
// Control-flow integrity monitor on the commit stage: call/return marker checks and,
// when CFI_SHADOW_STACK_EN is defined, a circular shadow stack checking return landings.
module cfi_commit_monitor
  import cfi_commit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned SS_DEPTH        = 8,
  parameter fu_op        MARKER_OP       = ADD,
  parameter logic [4:0]  MARKER_RD       = 5'd0,
  parameter logic [4:0]  MARKER_RS1      = 5'd0,
  parameter logic [4:0]  MARKER_IMM_CALL = 5'h2,
  parameter logic [4:0]  MARKER_IMM_RET  = 5'h1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  cfi_commit_monitor_if.slave mon
);

  if ((NR_COMMIT_PORTS < 1) || (NR_COMMIT_PORTS > 4) || (SS_DEPTH < 2) || (SS_DEPTH > 64) ||
      ((SS_DEPTH & (SS_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("cfi_commit_monitor: NR_COMMIT_PORTS must be 1..4, SS_DEPTH a power of two 2..64");
  end

  typedef enum logic [1:0] {IDLE, WAIT_CALL_MK, WAIT_RET_MK} state_e;

  state_e     state_d, state_q;
  exception_t exc_d, exc_q;
  logic [4:0] status_d, status_q;

`ifdef CFI_SHADOW_STACK_EN
  localparam int unsigned PTR_W = $clog2(SS_DEPTH);
  localparam int unsigned CNT_W = $clog2(SS_DEPTH + 1);

  logic [63:0]      ss_mem_d [SS_DEPTH];
  logic [63:0]      ss_mem_q [SS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [63:0]      ret_tgt_d, ret_tgt_q;
  // Cleared when the pending return popped an empty stack: its landing goes unchecked.
  logic             ret_chk_d, ret_chk_q;
`endif

  always_comb begin
    logic in_stream, is_call, is_ret, is_mk_call, is_mk_ret, viol, reported;
    // NOTE: every *_d and local gets a value before any conditional use, so no latch is inferred.
    state_d     = state_q;
    exc_d       = '0;
    status_d    = status_q;
    status_d[0] = mon.en_i;
    in_stream   = 1'b1;
    reported    = 1'b0;
    is_call     = 1'b0;
    is_ret      = 1'b0;
    is_mk_call  = 1'b0;
    is_mk_ret   = 1'b0;
    viol        = 1'b0;
`ifdef CFI_SHADOW_STACK_EN
    ss_mem_d  = ss_mem_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ret_tgt_d = ret_tgt_q;
    ret_chk_d = ret_chk_q;
`endif

    // NOTE: blocking assignments let each port see the state left behind by the port before it.
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      in_stream  = in_stream & mon.commit_ack_i[i];
      is_call    = ((mon.commit_instr_i[i].op == JAL) || (mon.commit_instr_i[i].op == JALR)) &&
                   (mon.commit_instr_i[i].rd != 5'd0);
      is_ret     = (mon.commit_instr_i[i].op == JALR) && (mon.commit_instr_i[i].rd == 5'd0) &&
                   (mon.commit_instr_i[i].rs1 == 5'd1);
      is_mk_call = (mon.commit_instr_i[i].op == MARKER_OP) && (mon.commit_instr_i[i].rd == MARKER_RD) &&
                   (mon.commit_instr_i[i].rs1 == MARKER_RS1) &&
                   (mon.commit_instr_i[i].result[4:0] == MARKER_IMM_CALL);
      is_mk_ret  = (mon.commit_instr_i[i].op == MARKER_OP) && (mon.commit_instr_i[i].rd == MARKER_RD) &&
                   (mon.commit_instr_i[i].rs1 == MARKER_RS1) &&
                   (mon.commit_instr_i[i].result[4:0] == MARKER_IMM_RET);
      viol       = 1'b0;

      if (in_stream && mon.commit_instr_i[i].ex.valid) begin
        state_d = IDLE;
      end else if (in_stream) begin
        case (state_d)
          WAIT_CALL_MK: begin
            if (!is_mk_call) begin
              viol        = 1'b1;
              status_d[1] = 1'b1;
            end
          end
          WAIT_RET_MK: begin
            if (!is_mk_ret) begin
              viol        = 1'b1;
              status_d[1] = 1'b1;
            end
`ifdef CFI_SHADOW_STACK_EN
            else if (ret_chk_d && (mon.commit_instr_i[i].pc != ret_tgt_d)) begin
              viol        = 1'b1;
              status_d[2] = 1'b1;
            end
`endif
          end
          default: ;
        endcase

        // The checked entry is then classified afresh, so a call here rearms the FSM.
        state_d = IDLE;
        if (is_call) begin
          state_d = WAIT_CALL_MK;
`ifdef CFI_SHADOW_STACK_EN
          ss_mem_d[wr_ptr_d] = mon.commit_instr_i[i].pc +
                               (mon.commit_instr_i[i].is_compressed ? 64'd2 : 64'd4);
          wr_ptr_d = wr_ptr_d + 1'b1;
          if (count_d == CNT_W'(SS_DEPTH)) begin
            status_d[3] = 1'b1;
          end else begin
            count_d = count_d + 1'b1;
          end
`endif
        end else if (is_ret) begin
          state_d = WAIT_RET_MK;
`ifdef CFI_SHADOW_STACK_EN
          if (count_d == '0) begin
            status_d[4] = 1'b1;
            ret_chk_d   = 1'b0;
          end else begin
            wr_ptr_d  = wr_ptr_d - 1'b1;
            ret_tgt_d = ss_mem_d[wr_ptr_d];
            count_d   = count_d - 1'b1;
            ret_chk_d = 1'b1;
          end
`endif
        end

        if (viol && mon.en_i && !reported) begin
          reported    = 1'b1;
          exc_d.valid = 1'b1;
          exc_d.cause = BREAKPOINT;
          exc_d.tval  = mon.commit_instr_i[i].pc;
          state_d     = IDLE;
        end
      end
    end

    if (mon.flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      exc_q     <= '0;
      status_q  <= '0;
`ifdef CFI_SHADOW_STACK_EN
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ret_tgt_q <= '0;
      ret_chk_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      status_q  <= status_d;
`ifdef CFI_SHADOW_STACK_EN
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ret_tgt_q <= ret_tgt_d;
      ret_chk_q <= ret_chk_d;
`endif
    end
  end

`ifdef CFI_SHADOW_STACK_EN
  // NOTE: stack storage is deliberately not reset; count_q == 0 already marks every slot empty.
  always_ff @(posedge clk_i) begin
    ss_mem_q <= ss_mem_d;
  end
`endif

  assign mon.exception_o = exc_q;
  assign mon.status_o    = status_q;

endmodule

// File: tb/tb_cfi_commit_monitor.sv
// Table-driven bench for cfi_commit_monitor; expected results flow through a scoreboard queue.
// Expectations follow CFI_SHADOW_STACK_EN so the same table serves both builds.
module tb_cfi_commit_monitor;
  import cfi_commit_pkg::*;

  localparam int unsigned NP    = 3;
  localparam int unsigned DEPTH = 8;
`ifdef CFI_SHADOW_STACK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  cfi_commit_monitor_if #(.NR_COMMIT_PORTS(NP)) bus ();

  cfi_commit_monitor #(
    .NR_COMMIT_PORTS(NP),
    .SS_DEPTH       (DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .mon  (bus)
  );

  typedef struct packed {
    logic                         rst;
    logic                         en;
    logic                         flush;
    logic [NP-1:0]                ack;
    scoreboard_entry_t [NP-1:0]   instr;
    logic                         exp_valid;
    logic [63:0]                  exp_tval;
    logic [4:0]                   exp_status;
  } vec_t;

  typedef struct packed {
    exception_t exc;
    logic [4:0] status;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic scoreboard_entry_t ent(input fu_op op, input logic [63:0] pc, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [63:0] res, input logic comp);
    scoreboard_entry_t e;
    e               = '0;
    e.op            = op;
    e.pc            = pc;
    e.rd            = rd;
    e.rs1           = rs1;
    e.result        = res;
    e.is_compressed = comp;
    return e;
  endfunction

  function automatic scoreboard_entry_t jal(input logic [63:0] pc, input logic comp);
    return ent(JAL, pc, 5'd1, 5'd0, 64'd0, comp);
  endfunction
  function automatic scoreboard_entry_t ret(input logic [63:0] pc);
    return ent(JALR, pc, 5'd0, 5'd1, 64'd0, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mkc(input logic [63:0] pc);
    return ent(ADD, pc, 5'd0, 5'd0, 64'd2, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mkr(input logic [63:0] pc);
    return ent(ADD, pc, 5'd0, 5'd0, 64'd1, 1'b0);
  endfunction
  function automatic scoreboard_entry_t add3(input logic [63:0] pc);
    return ent(ADD, pc, 5'd0, 5'd0, 64'd3, 1'b0);
  endfunction
  function automatic scoreboard_entry_t alu(input logic [63:0] pc, input logic [4:0] rd);
    return ent(ADD, pc, rd, 5'd2, 64'h55, 1'b0);
  endfunction
  function automatic scoreboard_entry_t exe(input logic [63:0] pc);
    scoreboard_entry_t e;
    e          = ent(ADD, pc, 5'd7, 5'd2, 64'd0, 1'b0);
    e.ex.valid = 1'b1;
    e.ex.cause = 64'd2;
    return e;
  endfunction

  // st is the expected sticky {underflow, overflow, mismatch, marker}; status[0] is the vector's en.
  function automatic void add(input logic r, input logic en, input logic fl, input logic [NP-1:0] ack,
                              input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                              input scoreboard_entry_t e2, input logic ev, input logic [63:0] tv,
                              input logic [3:0] st);
    vec_t v;
    v.rst        = r;
    v.en         = en;
    v.flush      = fl;
    v.ack        = ack;
    v.instr      = {e2, e1, e0};
    v.exp_valid  = ev & ~r;
    v.exp_tval   = tv;
    v.exp_status = r ? 5'd0 : {st, en};
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    scoreboard_entry_t z;
    vec_t v;
    exp_t e;
    exp_t got;
    logic s;
    z = '0;
    s = SHADOW;

    bus.en_i           = 1'b1;
    bus.flush_i        = 1'b0;
    bus.commit_ack_i   = '0;
    bus.commit_instr_i = '0;

    // Reset with traffic, then call/ret pair with correct markers and landing.
    add(1, 1, 0, 3'b011, jal(64'h100, 0), mkc(64'h800), z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b011, jal(64'h100, 0), mkc(64'h800), z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b011, ret(64'h810), mkr(64'h104), z, 0, 0, 4'b0000);
    // Ret alone, then a non-marker ADD x0,x0,3 in the next cycle.
    add(0, 1, 0, 3'b011, jal(64'h180, 0), mkc(64'h900), z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b001, ret(64'h910), z, z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b001, add3(64'h200), z, z, 1, 64'h200, 4'b0001);
    // Marker on port 2 behind an ack gap must be ignored.
    add(0, 1, 0, 3'b101, jal(64'h400, 0), z, mkc(64'h408), 0, 0, 4'b0001);
    add(0, 1, 0, 3'b001, alu(64'h410, 2), z, z, 1, 64'h410, 4'b0001);
    add(0, 1, 0, 3'b011, ret(64'h420), mkr(64'h404), z, 0, 0, 4'b0001);
    // Back-to-back violations, each with its own tval.
    add(0, 1, 0, 3'b011, jal(64'h500, 0), alu(64'h600, 3), z, 1, 64'h600, 4'b0001);
    add(0, 1, 0, 3'b011, jal(64'h700, 0), jal(64'h710, 0), z, 1, 64'h710, 4'b0001);
    // Full three-port streams.
    add(0, 1, 0, 3'b111, jal(64'hF00, 0), mkc(64'hF80), alu(64'hF90, 2), 0, 0, 4'b0001);
    add(0, 1, 0, 3'b111, jal(64'h1100, 0), alu(64'h1110, 4), mkc(64'h1120), 1, 64'h1110, 4'b0001);
    add(0, 1, 0, 3'b111, alu(64'h1200, 1), jal(64'h1210, 0), alu(64'h1220, 3), 1, 64'h1220, 4'b0001);
    // Reset mid-sequence drops the pending call and the sticky flags.
    add(0, 1, 0, 3'b001, jal(64'hA00, 0), z, z, 0, 0, 4'b0001);
    add(1, 1, 0, 3'b000, z, z, z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b001, alu(64'hA10, 5), z, z, 0, 0, 4'b0000);
    // Compressed call: landing should be 0x302, so 0x304 mismatches.
    add(0, 1, 0, 3'b011, jal(64'h300, 1), mkc(64'hB00), z, 0, 0, 4'b0000);
    add(0, 1, 0, 3'b011, ret(64'hB10), mkr(64'h304), z, s, 64'h304, {1'b0, 1'b0, s, 1'b0});
    // DEPTH+1 nested calls, then DEPTH+1 returns landing correctly.
    for (int k = 0; k <= int'(DEPTH); k++) begin
      add(0, 1, 0, 3'b011, jal(64'h1000 + 64'(k) * 64'h10, 0), mkc(64'h2000 + 64'(k) * 64'h10), z,
          0, 0, {1'b0, s & (k == int'(DEPTH)), s, 1'b0});
    end
    for (int k = int'(DEPTH); k >= 0; k--) begin
      add(0, 1, 0, 3'b011, ret(64'h3000), mkr(64'h1004 + 64'(k) * 64'h10), z,
          0, 0, {s & (k == 0), s, s, 1'b0});
    end
    // Flush in the ret cycle, then a non-marker commit.
    add(0, 1, 1, 3'b001, ret(64'hC00), z, z, 0, 0, {s, s, s, 1'b0});
    add(0, 1, 0, 3'b001, alu(64'hC10, 6), z, z, 0, 0, {s, s, s, 1'b0});
    // Trap entry clears the pending call.
    add(0, 1, 0, 3'b001, jal(64'hE00, 0), z, z, 0, 0, {s, s, s, 1'b0});
    add(0, 1, 0, 3'b011, exe(64'hE10), alu(64'hE14, 7), z, 0, 0, {s, s, s, 1'b0});
    // Violation with reporting disabled only sets the sticky flag.
    add(0, 0, 0, 3'b001, ret(64'hD00), z, z, 0, 0, {s, s, s, 1'b0});
    add(0, 0, 0, 3'b001, add3(64'hD10), z, z, 0, 0, {s, s, s, 1'b1});
    add(0, 1, 0, 3'b000, z, z, z, 0, 0, {s, s, s, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      v                  = vecs[i];
      rst_i              = v.rst;
      bus.en_i           = v.en;
      bus.flush_i        = v.flush;
      bus.commit_ack_i   = v.ack;
      bus.commit_instr_i = v.instr;
      e.exc.valid        = v.exp_valid;
      e.exc.cause        = v.exp_valid ? BREAKPOINT : 64'd0;
      e.exc.tval         = v.exp_valid ? v.exp_tval : 64'd0;
      e.status           = v.exp_status;
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      got = sb_q.pop_front();
      check($sformatf("v%0d exception", i), {63'd0, bus.exception_o}, {63'd0, got.exc});
      check($sformatf("v%0d status", i), {187'd0, bus.status_o}, {187'd0, got.status});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
